// File: rtl/iterative_divider_if.sv
// Handshake/data bundle for iterative_divider.
// master: the requester driving operands; slave: the divider itself.
interface iterative_divider_if;
  logic        i_start;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic [1:0]  i_op;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  modport master (
    output i_start, i_operand_a, i_operand_b, i_op,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_operand_a, i_operand_b, i_op,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/iterative_divider.sv
// RV32M-style iterative divider (DIV/DIVU/REM/REMU).
// 32 restoring shift-subtract steps on operand magnitudes, one per cycle,
// then a single DONE cycle carrying the o_valid strobe.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow are
// resolved at acceptance and skip the iteration phase (results unchanged).
module iterative_divider (
  input  logic               i_clk,
  input  logic               i_rst_n,
  iterative_divider_if.slave bus
);

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dvsr_r;
  logic [DATA_W-1:0] a_raw_r;
  logic [DATA_W-1:0] result_r;
  logic              is_rem_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic              div0_r;
  logic              ovf_r;

  // Magnitude of a possibly signed operand; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v,
                                              input logic is_signed);
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    if (is_signed && (sv < 0)) return unsigned'(-sv);
    return v;
  endfunction

  // Two's-complement negate when en is set.
  function automatic logic [DATA_W-1:0] f_negate(input logic [DATA_W-1:0] v,
                                                 input logic en);
    return en ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Final result selection: special cases first, then sign fix-up of the
  // magnitude quotient/remainder.
  function automatic logic [DATA_W-1:0] f_finish(input logic              is_rem,
                                                 input logic [DATA_W-1:0] q,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic              neg_q,
                                                 input logic              neg_r,
                                                 input logic              div0,
                                                 input logic              ovf,
                                                 input logic [DATA_W-1:0] a_raw);
    if (div0) return is_rem ? a_raw : {DATA_W{1'b1}};
    if (ovf)  return is_rem ? {DATA_W{1'b0}} : {1'b1, {(DATA_W-1){1'b0}}};
    return is_rem ? f_negate(r, neg_r) : f_negate(q, neg_q);
  endfunction

  logic              acc_signed;
  logic              acc_div0;
  logic              acc_ovf;
  logic [DATA_W:0]   shift_c;
  logic [DATA_W:0]   diff_c;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;

  // Special-case detection on the live inputs, used at acceptance.
  always_comb begin
    acc_signed = ~bus.i_op[0];
    acc_div0   = (bus.i_operand_b == {DATA_W{1'b0}});
    acc_ovf    = acc_signed &&
                 (bus.i_operand_a == {1'b1, {(DATA_W-1){1'b0}}}) &&
                 (bus.i_operand_b == {DATA_W{1'b1}});
  end

  // One restoring step: shift in next dividend bit, trial 33-bit subtract.
  always_comb begin
    shift_c = {rem_r, quo_r[DATA_W-1]};
    diff_c  = shift_c - {1'b0, dvsr_r};
    if (!diff_c[DATA_W]) begin
      rem_nx = diff_c[DATA_W-1:0];
      quo_nx = {quo_r[DATA_W-2:0], 1'b1};
    end else begin
      rem_nx = shift_c[DATA_W-1:0];
      quo_nx = {quo_r[DATA_W-2:0], 1'b0};
    end
  end

  // Control FSM plus working registers; reset clears everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 5'd0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      a_raw_r  <= '0;
      result_r <= '0;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            a_raw_r  <= bus.i_operand_a;
            is_rem_r <= bus.i_op[1];
            neg_q_r  <= acc_signed & (bus.i_operand_a[DATA_W-1] ^ bus.i_operand_b[DATA_W-1]);
            neg_r_r  <= acc_signed & bus.i_operand_a[DATA_W-1];
            div0_r   <= acc_div0;
            ovf_r    <= acc_ovf;
            rem_r    <= '0;
            quo_r    <= f_mag(bus.i_operand_a, acc_signed);
            dvsr_r   <= f_mag(bus.i_operand_b, acc_signed);
            cnt      <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
            if (acc_div0 || acc_ovf) begin
              state    <= ST_DONE;
              result_r <= f_finish(bus.i_op[1], '0, '0, 1'b0, 1'b0,
                                   acc_div0, acc_ovf, bus.i_operand_a);
            end else begin
              state <= ST_CALC;
            end
`else
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= ST_DONE;
            result_r <= f_finish(is_rem_r, quo_nx, rem_nx, neg_q_r, neg_r_r,
                                 div0_r, ovf_r, a_raw_r);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy   = (state != ST_IDLE);
  assign bus.o_valid  = (state == ST_DONE);
  assign bus.o_result = result_r;

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port i_start, input, 1, request; accepted only when o_busy=0.
REQ-004 SHALL have port i_operand_a, input, 32, dividend.
REQ-005 SHALL have port i_operand_b, input, 32, divisor.
REQ-006 SHALL have port i_op, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-007 SHALL have port o_busy, output, 1, operation in progress.
REQ-008 SHALL have port o_valid, output, 1, one-cycle result strobe.
REQ-009 SHALL have port o_result, output, 32, quotient (op[1]=0) or remainder (op[1]=1).

Function
REQ-010 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-011 SHALL, in IDLE with i_start=1 at cycle T, register operands and op, set o_busy=1 from T+1, enter CALC.
REQ-012 SHALL ignore i_start while o_busy=1; captured operands unaffected by input changes after T.
REQ-013 SHALL perform 32 restoring shift-subtract iterations on operand magnitudes in CALC, one per cycle (T+1..T+32), via a 33-bit subtract.
REQ-014 SHALL enter DONE at T+33: o_valid=1 for exactly that cycle, o_busy=1; return to IDLE at T+34 (o_busy=0).
REQ-015 SHALL hold o_result stable from its valid cycle until the next accepted i_start completes.
REQ-016 SHALL, for signed ops, take magnitudes of operands; negate quotient when operand signs differ; give remainder the sign of the dividend.
REQ-017 SHALL return on divide-by-zero: quotient 0xFFFFFFFF (signed and unsigned), remainder = i_operand_a unmodified.
REQ-018 SHALL return on signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0x00000000.
REQ-019 SHALL accept a new i_start in the IDLE cycle directly following DONE (back-to-back spacing 34 cycles).
REQ-020 SHALL never assert o_valid except in DONE.

Reset
REQ-021 SHALL, with i_rst_n=0 at a rising edge, force state IDLE, o_busy=0, o_valid=0, o_result=0x00000000, clear iteration counter and working registers.
REQ-022 SHALL abandon any operation on reset mid-CALC or in DONE with no o_valid pulse; i_start sampled during reset ignored.

Configuration
REQ-023 SHALL, with DIV_EARLY_OUT_EN defined, detect divide-by-zero and signed overflow at acceptance and skip CALC: DONE (o_valid=1) at T+1, IDLE at T+2.
REQ-024 SHALL, without DIV_EARLY_OUT_EN, run these cases through full 32-cycle CALC (o_valid at T+33) with results per REQ-017/018.
REQ-025 SHALL produce identical o_result values with or without DIV_EARLY_OUT_EN; only latency differs.

Verification
REQ-026 SHALL cover DIVU 100/7 -> o_valid at T+33, o_result=0x0000000E; REMU same operands -> 0x00000002.
REQ-027 SHALL cover DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD.
REQ-028 SHALL cover DIV 0x12345678/0 -> 0xFFFFFFFF, REM -> 0x12345678; latency T+1 with DIV_EARLY_OUT_EN, T+33 without.
REQ-029 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; DIVU same -> 0x00000000.
REQ-030 SHALL cover i_start pulsed and operands changed at T+5 during CALC -> ignored, result of original operands at T+33, next start accepted at T+34.
REQ-031 SHALL cover i_rst_n=0 at T+10 -> o_busy=0, o_valid=0, o_result=0 next cycle; no strobe afterward; fresh start then completes normally.
